vote_logger: RTL and testbench

Front-end of the voting machine: synchronizes and debounces the four raw candidate buttons, registers one vote per accepted press while in voting mode, and maintains the four 8-bit candidate tallies. It produces `valid_vote_casted`, the `candidateN_vote` counts and the debounced `candidateN_button_press` levels consumed by the mode/LED controller. Votes are accepted only in voting mode (`mode = 0`). Result-display mode (`mode = 1`) leaves the tallies frozen.

---
 rtl/vote_logger.sv | 168 ++++++++++++++++
 tb/tb_vote_logger.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_logger.sv
// vote_logger
//   Voting-machine front end. Each raw candidate button is passed through a
//   2-FF synchronizer and a counter-based debouncer. A small FSM turns a
//   debounced press into exactly one tally increment, enforces a lockout
//   window after each accepted vote, and discards multi-button presses.
//
// Ports
//   clk                       system clock, rising edge
//   rst                       asynchronous reset, active low
//   mode                      0 = voting, 1 = result display (tallies frozen)
//   button1..button4          raw asynchronous candidate buttons, active high
//   candidate1..4_button_press debounced button levels
//   candidate1..4_vote        8-bit saturating vote tallies
//   valid_vote_casted         one-cycle pulse per accepted vote
//   vote_rejected             one-cycle pulse per discarded multi-button press
module vote_logger #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int LOCKOUT_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       candidate1_button_press,
    output logic       candidate2_button_press,
    output logic       candidate3_button_press,
    output logic       candidate4_button_press,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote,
    output logic       valid_vote_casted,
    output logic       vote_rejected
);

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    logic [3:0]  btn_raw;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  db;
    logic [15:0] db_cnt [4];

    state_t      state;
    logic [15:0] lock_cnt;
    logic [7:0]  tally [4];

    logic        single_press;
    logic        multi_press;
    logic [1:0]  sel;
    logic [2:0]  n_db;

    // Tally increment that sticks at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign btn_raw = {button4, button3, button2, button1};

    // Synchronizer + debouncer. The counter measures how long s2 has
    // disagreed with the debounced level; any agreement restarts it, so
    // only an unbroken run of DEBOUNCE_CYCLES flips the level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        n_db = {2'b00, db[0]} + {2'b00, db[1]} + {2'b00, db[2]} + {2'b00, db[3]};
        single_press = (n_db == 3'd1);
        multi_press  = (n_db >= 3'd2);
        sel = 2'd0;
        case (db)
            4'b0010: sel = 2'd1;
            4'b0100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    // Vote FSM. Display mode overrides everything and parks the FSM in
    // WAIT_RELEASE, so a button held across the mode switch must be
    // released before it can vote.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            lock_cnt          <= '0;
            valid_vote_casted <= 1'b0;
            vote_rejected     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tally[i] <= '0;
            end
        end else begin
            valid_vote_casted <= 1'b0;
            vote_rejected     <= 1'b0;
            if (mode) begin
                state <= WAIT_RELEASE;
            end else begin
                case (state)
                    IDLE: begin
                        if (single_press) begin
                            tally[sel]        <= sat_inc(tally[sel]);
                            valid_vote_casted <= 1'b1;
                            lock_cnt          <= LOCK_LOAD;
                            state             <= LOCKOUT;
                        end else if (multi_press) begin
                            vote_rejected <= 1'b1;
                            state         <= WAIT_RELEASE;
                        end
                    end
                    LOCKOUT: begin
                        if (lock_cnt == 16'd0) begin
                            state <= WAIT_RELEASE;
                        end else begin
                            lock_cnt <= lock_cnt - 16'd1;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (db == 4'b0000) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign candidate1_button_press = db[0];
    assign candidate2_button_press = db[1];
    assign candidate3_button_press = db[2];
    assign candidate4_button_press = db[3];

    assign candidate1_vote = tally[0];
    assign candidate2_vote = tally[1];
    assign candidate3_vote = tally[2];
    assign candidate4_vote = tally[3];

endmodule

// File: tb/tb_vote_logger.sv
module tb_vote_logger;

    localparam int DB = 10;
    localparam int LK = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0;
    logic       p1, p2, p3, p4;
    logic [7:0] v1, v2, v3, v4;
    logic       valid, rej;

    logic [3:0] press;
    logic [7:0] tally [4];

    vote_logger #(.DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LK)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .button1(b1), .button2(b2), .button3(b3), .button4(b4),
        .candidate1_button_press(p1), .candidate2_button_press(p2),
        .candidate3_button_press(p3), .candidate4_button_press(p4),
        .candidate1_vote(v1), .candidate2_vote(v2),
        .candidate3_vote(v3), .candidate4_vote(v4),
        .valid_vote_casted(valid), .vote_rejected(rej)
    );

    always #5 clk = ~clk;

    assign press = {p4, p3, p2, p1};
    assign tally[0] = v1;
    assign tally[1] = v2;
    assign tally[2] = v3;
    assign tally[3] = v4;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    // Debounce: a level flips once the synchronized input (raw sampled two
    // edges earlier) has disagreed with it on DB consecutive edges.
    // Vote rule: timestamps -- after a vote at edge A nothing happens up to
    // edge A+LK; then the machine waits for all buttons up before voting again.
    bit [63:0] m_hist [4];
    bit        m_db [4];
    int        m_tally [4];
    bit        m_valid, m_rej, m_wait;
    int        m_cyc, m_lock_end;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = '0; m_db[i] = 1'b0; m_tally[i] = 0;
            end
            m_valid = 0; m_rej = 0; m_wait = 0; m_cyc = 0; m_lock_end = -1;
        end else begin
            int ones;
            int who;
            bit all_diff;
            bit [3:0] raw;
            m_cyc++;
            m_valid = 0;
            m_rej = 0;
            ones = 0;
            who = 0;
            for (int i = 0; i < 4; i++) if (m_db[i]) begin ones++; who = i; end
            if (mode) begin
                m_lock_end = -1;
                m_wait = 1;
            end else if (m_cyc <= m_lock_end) begin
                if (m_cyc == m_lock_end) m_wait = 1;
            end else if (m_wait) begin
                if (ones == 0) m_wait = 0;
            end else if (ones == 1) begin
                m_valid = 1;
                if (m_tally[who] < 255) m_tally[who]++;
                m_lock_end = m_cyc + LK;
            end else if (ones >= 2) begin
                m_rej = 1;
                m_wait = 1;
            end
            raw = {b4, b3, b2, b1};
            for (int i = 0; i < 4; i++) begin
                all_diff = 1;
                for (int k = 1; k <= DB; k++) if (m_hist[i][k] == m_db[i]) all_diff = 0;
                if (all_diff) m_db[i] = ~m_db[i];
                m_hist[i] = {m_hist[i][62:0], raw[i]};
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cyc%0d_press%0d", cyc, i + 1), int'(press[i]), int'(m_db[i]));
            chk($sformatf("cyc%0d_vote%0d", cyc, i + 1), int'(tally[i]), m_tally[i]);
        end
        chk($sformatf("cyc%0d_valid", cyc), int'(valid), int'(m_valid));
        chk($sformatf("cyc%0d_rejected", cyc), int'(rej), int'(m_rej));
    end

    // ---------------- event monitor ----------------
    int       last_valid = -1, last_rej = -1, nvalid = 0, nrej = 0;
    int       rise [4] = '{-1, -1, -1, -1};
    int       fall [4] = '{-1, -1, -1, -1};
    bit [3:0] prev = '0;
    always @(negedge clk) begin
        if (valid) begin last_valid = cyc; nvalid++; end
        if (rej) begin last_rej = cyc; nrej++; end
        for (int i = 0; i < 4; i++) begin
            if (press[i] && !prev[i]) rise[i] = cyc;
            if (!press[i] && prev[i]) fall[i] = cyc;
        end
        prev = press;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, t1, v0, r0;
        // reset state
        tick(2);
        chk("reset_vote1", int'(v1), 0);
        chk("reset_vote4", int'(v4), 0);
        chk("reset_press", int'(press), 0);
        chk("reset_valid", int'(valid), 0);
        rst = 1'b1;
        tick(3);

        // single clean vote
        v0 = nvalid; t0 = cyc;
        b2 = 1; tick(30); b2 = 0; t1 = cyc; tick(40);
        chk("single_valid_edge", last_valid - t0, 13);
        chk("single_press_rise", rise[1] - t0, 12);
        chk("single_press_fall", fall[1] - t1, 12);
        chk("single_pulses", nvalid - v0, 1);
        chk("single_vote2", int'(v2), 1);
        chk("single_vote1", int'(v1), 0);

        // bounce filter
        v0 = nvalid; t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            b1 = ((k / 3) % 2 == 0);
            tick(1);
        end
        b1 = 0; tick(30);
        chk("bounce_press_seen", int'(rise[0] >= t0), 0);
        chk("bounce_pulses", nvalid - v0, 0);
        chk("bounce_vote1", int'(v1), 0);

        // held button, lockout, re-press
        v0 = nvalid;
        b3 = 1; tick(200); b3 = 0; tick(50);
        chk("held_pulses", nvalid - v0, 1);
        t0 = cyc;
        b3 = 1; tick(30); b3 = 0; tick(40);
        chk("repress_valid_edge", last_valid - t0, 13);
        chk("repress_vote3", int'(v3), 2);

        // simultaneous press
        v0 = nvalid; r0 = nrej; t0 = cyc;
        b1 = 1; b4 = 1; tick(30); b1 = 0; b4 = 0; tick(40);
        chk("simul_rej_pulses", nrej - r0, 1);
        chk("simul_rej_edge", last_rej - t0, 13);
        chk("simul_valid_pulses", nvalid - v0, 0);
        chk("simul_vote1", int'(v1), 0);
        chk("simul_vote4", int'(v4), 0);
        b1 = 1; tick(30); b1 = 0; tick(40);
        chk("after_simul_vote1", int'(v1), 1);

        // mode interaction
        v0 = nvalid;
        mode = 1; tick(2); t0 = cyc;
        b2 = 1; tick(30);
        chk("mode1_press_rise", rise[1] - t0, 12);
        chk("mode1_pulses", nvalid - v0, 0);
        mode = 0; tick(30);
        chk("mode_switch_pulses", nvalid - v0, 0);
        b2 = 0; tick(40);
        chk("mode_vote2_frozen", int'(v2), 1);
        b2 = 1; tick(30); b2 = 0; tick(40);
        chk("mode_repress_vote2", int'(v2), 2);
        chk("mode_repress_pulses", nvalid - v0, 1);

        // saturation
        v0 = nvalid;
        for (int k = 0; k < 256; k++) begin
            b4 = 1; tick(16); b4 = 0; tick(16);
        end
        tick(10);
        chk("sat_pulses", nvalid - v0, 256);
        chk("sat_vote4", int'(v4), 255);

        // reset in the middle of a lockout
        b4 = 1;
        for (int k = 0; k < 50 && !valid; k++) @(negedge clk);
        chk("lockout_vote_seen", int'(valid), 1);
        tick(3);
        @(posedge clk);
        #2 rst = 0; b4 = 0;
        #1;
        chk("midreset_vote4", int'(v4), 0);
        chk("midreset_vote2", int'(v2), 0);
        chk("midreset_press", int'(press), 0);
        chk("midreset_valid", int'(valid), 0);
        chk("midreset_rejected", int'(rej), 0);
        @(negedge clk); rst = 1;
        tick(5);
        t0 = cyc;
        b1 = 1; tick(30); b1 = 0; tick(40);
        chk("postreset_valid_edge", last_valid - t0, 13);
        chk("postreset_vote1", int'(v1), 1);
        chk("postreset_vote4", int'(v4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
